// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer: FSM states, inst bus
// field positions, idle instruction word and xmem weight base address.
package core_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, W_L0, W_LOAD, W_GAP, X_L0, EXEC, DRAIN, P_WR, ACC, DONE
    } state_t;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    localparam int INST_ACC      = 33;
    localparam int INST_CEN_P    = 32;
    localparam int INST_WEN_P    = 31;
    localparam int INST_AP_LSB   = 20;
    localparam int INST_CEN_X    = 19;
    localparam int INST_WEN_X    = 18;
    localparam int INST_AX_LSB   = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXEC     = 1;
    localparam int INST_LOAD     = 0;

    // Both SRAMs deselected (CEN/WEN high), every strobe low.
    localparam logic [INST_W-1:0] IDLE_INST  = 34'h1800C0000;
    localparam logic [ADDR_W-1:0] XMEM_WBASE = 11'h400;

    // Kernel is 3x3: kernel position k = ki*KDIM + kj.
    localparam int KDIM = 3;

endpackage

// File: rtl/core_acc_addr_gen.sv
// Psum read address generator for the ACC phase: walks outputs (r,c) in raster
// order and, per output, kernel positions (ki,kj) over the stored psum planes.
module core_acc_addr_gen
    import core_seq_pkg::*;
#(
    parameter int LEN_NIJ = 64,
    parameter int LEN_KIJ = 9,
    parameter int I_W     = 8,
    parameter int O_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [31:0]       step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int CW = 8;

    logic [CW-1:0] r, c, ki, kj;
    logic [CW-1:0] r_n, c_n, ki_n, kj_n;
    logic          active_q;
    logic [31:0]   k_n;

    // Counters are computed for the step the sequencer is about to enter, so the
    // address lines up with an inst word that is registered from next-state.
    always_comb begin
        r_n  = r;
        c_n  = c;
        ki_n = ki;
        kj_n = kj;
        if (!active) begin
            r_n  = '0;
            c_n  = '0;
            ki_n = '0;
            kj_n = '0;
        end else if (active_q && step == 0) begin
            ki_n = '0;
            kj_n = '0;
            if (c == CW'(O_W - 1)) begin
                c_n = '0;
                r_n = r + 1'b1;
            end else begin
                c_n = c + 1'b1;
            end
        end else if (step <= 1) begin
            ki_n = '0;
            kj_n = '0;
        end else if (step <= LEN_KIJ) begin
            if (kj == CW'(KDIM - 1)) begin
                kj_n = '0;
                ki_n = ki + 1'b1;
            end else begin
                kj_n = kj + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r        <= '0;
            c        <= '0;
            ki       <= '0;
            kj       <= '0;
            active_q <= 1'b0;
        end else begin
            r        <= r_n;
            c        <= c_n;
            ki       <= ki_n;
            kj       <= kj_n;
            active_q <= active;
        end
    end

    assign k_n  = 32'(ki_n) * KDIM + 32'(kj_n);
    assign addr = ADDR_W'(k_n * LEN_NIJ + (32'(r_n) + 32'(ki_n)) * I_W + 32'(c_n) + 32'(kj_n));
    assign last = (r == CW'(O_W - 1)) && (c == CW'(O_W - 1));

endmodule

// File: rtl/core_sequencer.sv
// Layer-run sequencer: drives the registered core instruction bus through weight
// load, input load, execute, drain and psum write per kij. Define CORE_SEQ_ACC_EN for ACC.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int COL     = 8,
    parameter int LEN_NIJ = 64,
    parameter int LEN_KIJ = 9,
    parameter int I_W     = 8,
    parameter int O_W     = 6,
    parameter int GAP     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              acc_clr,
    output logic              out_strobe
);
    localparam int KW = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1;

    if (COL < 1 || GAP < 1 || I_W < O_W + KDIM - 1 || LEN_NIJ < I_W * I_W) begin : g_cfg_err
        $error("core_sequencer: inconsistent tile/kernel/timing parameters");
    end

    state_t            state, state_n;
    logic [31:0]       t, t_n;
    logic [KW-1:0]     kij, kij_n;
    logic [INST_W-1:0] inst_n;

`ifdef CORE_SEQ_ACC_EN
    logic              clr_n, strobe_n;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_last;

    core_acc_addr_gen #(
        .LEN_NIJ(LEN_NIJ),
        .LEN_KIJ(LEN_KIJ),
        .I_W    (I_W),
        .O_W    (O_W)
    ) u_acc_addr_gen (
        .clk   (clk),
        .reset (reset),
        .active(state_n == ACC),
        .step  (t_n),
        .addr  (acc_addr),
        .last  (acc_last)
    );
`endif

    always_comb begin
        state_n = state;
        t_n     = t + 1;
        kij_n   = kij;
        case (state)
            IDLE: begin
                t_n = '0;
                if (start) begin
                    state_n = W_L0;
                    kij_n   = '0;
                end
            end
            W_L0:   if (t == COL)         begin state_n = W_LOAD; t_n = '0; end
            W_LOAD: if (t == 2 * COL - 1) begin state_n = W_GAP;  t_n = '0; end
            W_GAP:  if (t == GAP - 1)     begin state_n = X_L0;   t_n = '0; end
            X_L0:   if (t == LEN_NIJ)     begin state_n = EXEC;   t_n = '0; end
            EXEC:   if (t == LEN_NIJ - 1) begin state_n = DRAIN;  t_n = '0; end
            DRAIN: begin
                t_n = '0;
                if (ofifo_valid) state_n = P_WR;
            end
            P_WR: begin
                if (t == LEN_NIJ) begin
                    t_n = '0;
                    if (kij < KW'(LEN_KIJ - 1)) begin
                        kij_n   = kij + 1'b1;
                        state_n = W_L0;
                    end else begin
`ifdef CORE_SEQ_ACC_EN
                        state_n = ACC;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
`ifdef CORE_SEQ_ACC_EN
            ACC: begin
                if (t == LEN_KIJ + 2) begin
                    t_n = '0;
                    if (acc_last) state_n = DONE;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
                t_n     = '0;
            end
            default: begin
                state_n = IDLE;
                t_n     = '0;
            end
        endcase
    end

    // Decode from next-state so inst is a plain register aligned with state.
    always_comb begin
        inst_n                = IDLE_INST;
        inst_n[INST_IFIFO_WR] = 1'b0;
        inst_n[INST_IFIFO_RD] = 1'b0;
`ifdef CORE_SEQ_ACC_EN
        clr_n    = 1'b0;
        strobe_n = 1'b0;
`endif
        case (state_n)
            W_L0: begin
                if (t_n < COL) begin
                    inst_n[INST_CEN_X]              = 1'b0;
                    inst_n[INST_WEN_X]              = 1'b1;
                    inst_n[INST_AX_LSB +: ADDR_W]   = ADDR_W'(32'(XMEM_WBASE) + 32'(kij_n) * COL + t_n);
                end
                if (t_n != 0) inst_n[INST_L0_WR] = 1'b1;
            end
            W_LOAD: begin
                inst_n[INST_L0_RD] = 1'b1;
                inst_n[INST_LOAD]  = 1'b1;
            end
            X_L0: begin
                if (t_n < LEN_NIJ) begin
                    inst_n[INST_CEN_X]            = 1'b0;
                    inst_n[INST_WEN_X]            = 1'b1;
                    inst_n[INST_AX_LSB +: ADDR_W] = ADDR_W'(t_n);
                end
                if (t_n != 0) inst_n[INST_L0_WR] = 1'b1;
            end
            EXEC: begin
                inst_n[INST_L0_RD] = 1'b1;
                inst_n[INST_EXEC]  = 1'b1;
            end
            P_WR: begin
                if (t_n < LEN_NIJ) inst_n[INST_OFIFO_RD] = 1'b1;
                if (t_n != 0) begin
                    inst_n[INST_CEN_P]            = 1'b0;
                    inst_n[INST_WEN_P]            = 1'b0;
                    inst_n[INST_AP_LSB +: ADDR_W] = ADDR_W'(32'(kij_n) * LEN_NIJ + t_n - 1);
                end
            end
`ifdef CORE_SEQ_ACC_EN
            ACC: begin
                if (t_n == 0) clr_n = 1'b1;
                if (t_n >= 1 && t_n <= LEN_KIJ) begin
                    inst_n[INST_CEN_P]            = 1'b0;
                    inst_n[INST_WEN_P]            = 1'b1;
                    inst_n[INST_AP_LSB +: ADDR_W] = acc_addr;
                end
                // psum data arrives one cycle after the read address
                if (t_n >= 2 && t_n <= LEN_KIJ + 1) inst_n[INST_ACC] = 1'b1;
                if (t_n == LEN_KIJ + 2) strobe_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            kij   <= '0;
            inst  <= IDLE_INST;
        end else begin
            state <= state_n;
            t     <= t_n;
            kij   <= kij_n;
            inst  <= inst_n;
        end
    end

`ifdef CORE_SEQ_ACC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_clr    <= 1'b0;
            out_strobe <= 1'b0;
        end else begin
            acc_clr    <= clr_n;
            out_strobe <= strobe_n;
        end
    end
`else
    assign acc_clr    = 1'b0;
    assign out_strobe = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected psum addresses and
// done events into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        busy, done, acc_clr, out_strobe;

    localparam logic [33:0] IDLE_W = 34'h1800C0000;

    core_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .acc_clr    (acc_clr),
        .out_strobe (out_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_wr[$];
    logic [10:0] exp_rd[$];
    int          exp_done[$];

    logic [10:0] last_wr = '0;
    int          pwr_phases = 0;
    logic        prev_ofr = 1'b0;
    int          acc_hi = 0, clr_cnt = 0, strb_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected none", name, act);
    endtask

    // One full layer run: psum writes kij*64 + nij, plus ACC reads when built in.
    task automatic push_run();
        int tbl01[9] = '{1, 66, 131, 201, 266, 331, 401, 466, 531};
        for (int k = 0; k < 9; k++)
            for (int n = 0; n < 64; n++)
                exp_wr.push_back(11'(k * 64 + n));
`ifdef CORE_SEQ_ACC_EN
        for (int o = 0; o < 36; o++)
            for (int k = 0; k < 9; k++) begin
                int a;
                a = k * 64 + (o / 6 + k / 3) * 8 + (o % 6 + k % 3);
                if (o == 1) a = tbl01[k];
                exp_rd.push_back(11'(a));
            end
`endif
        exp_done.push_back(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_exec();
        int n = 0;
        while (!inst[1] && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) fail("exec_timeout", 64'(n));
    endtask

    task automatic wait_drain();
        int n = 0;
        wait_exec();
        while (inst[1] && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("drain_timeout", 64'(n));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 8000) begin @(negedge clk); n++; end
        if (n >= 8000) fail({name, "_done_timeout"}, 64'(n));
        else begin
            @(negedge clk);
            chk({name, "_done_1cyc"}, 64'(done), 64'd0);
            chk({name, "_busy_fall"}, 64'(busy), 64'd0);
            chk({name, "_inst_idle"}, 64'(inst), 64'(IDLE_W));
        end
    endtask

    assert property (@(posedge clk) disable iff (reset)
        !(inst[0] && inst[1]) && !(inst[2] && inst[3]))
        else $error("strobe exclusivity violated inst=%h", inst);

    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe_excl", 64'((inst[0] && inst[1]) || (inst[2] && inst[3])), 64'd0);
            if (!inst[32] && !inst[31]) begin
                last_wr = inst[30:20];
                if (exp_wr.size() == 0) fail("pmem_wr_unexpected", 64'(inst[30:20]));
                else chk("pmem_wr_addr", 64'(inst[30:20]), 64'(exp_wr.pop_front()));
            end
            if (!inst[32] && inst[31]) begin
                if (exp_rd.size() == 0) fail("pmem_rd_unexpected", 64'(inst[30:20]));
                else chk("pmem_rd_addr", 64'(inst[30:20]), 64'(exp_rd.pop_front()));
            end
            if (done) begin
                if (exp_done.size() == 0) fail("done_unexpected", 64'(done));
                else begin
                    void'(exp_done.pop_front());
                    chk("done_busy", 64'(busy), 64'd1);
                end
            end
            if (inst[6] && !prev_ofr) pwr_phases++;
            prev_ofr = inst[6];
            if (inst[33]) acc_hi++;
            if (acc_clr) clr_cnt++;
            if (out_strobe) strb_cnt++;
        end
    end

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inst", 64'(inst), 64'(IDLE_W));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_clr", 64'(acc_clr), 64'd0);
        chk("rst_strobe", 64'(out_strobe), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_inst", 64'(inst), 64'(IDLE_W));

        // Run A: first W_L0 cycles, DRAIN hold with ofifo_valid low, then full run
        base = pwr_phases;
        push_run();
        pulse_start();
        chk("wl0_cen_x", 64'(inst[19]), 64'd0);
        chk("wl0_addr0", 64'(inst[17:7]), 64'h400);
        chk("wl0_l0wr_t0", 64'(inst[2]), 64'd0);
        chk("wl0_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("wl0_l0wr_t1", 64'(inst[2]), 64'd1);
        chk("wl0_addr1", 64'(inst[17:7]), 64'h401);
        wait_drain();
        for (int i = 0; i < 50; i++) begin
            chk("drain_hold", 64'(inst), 64'(IDLE_W));
            start = (i == 10);
            @(negedge clk);
        end
        start = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        ofifo_valid = 1'b1;
        @(negedge clk);
        chk("pwr_ofifo_rd", 64'(inst[6]), 64'd1);
        chk("pwr_no_wr_t0", 64'(inst[32]), 64'd1);
        wait_done("runA");
        chk("runA_pwr_phases", 64'(pwr_phases - base), 64'd9);
        chk("runA_last_wr", 64'(last_wr), 64'd575);

        // Run B: reset in the middle of EXEC aborts without a done pulse
        repeat (3) @(negedge clk);
        pulse_start();
        wait_exec();
        repeat (5) @(negedge clk);
        chk("abort_in_exec", 64'(inst[1]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_inst", 64'(inst), 64'(IDLE_W));
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", 64'(busy), 64'd0);

        // Run C: normal run after the abort
        base = pwr_phases;
        push_run();
        pulse_start();
        chk("runC_addr0", 64'(inst[17:7]), 64'h400);
        wait_done("runC");
        chk("runC_pwr_phases", 64'(pwr_phases - base), 64'd9);
        chk("runC_last_wr", 64'(last_wr), 64'd575);

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
`ifdef CORE_SEQ_ACC_EN
        chk("acc_cycles", 64'(acc_hi), 64'd648);
        chk("acc_clr_count", 64'(clr_cnt), 64'd72);
        chk("out_strobe_count", 64'(strb_cnt), 64'd72);
`else
        chk("acc_cycles", 64'(acc_hi), 64'd0);
        chk("acc_clr_count", 64'(clr_cnt), 64'd0);
        chk("out_strobe_count", 64'(strb_cnt), 64'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
